// File: rtl/video_scanout_reader.sv
// video_scanout_reader
// Fetches one 384-pixel scanline (64 words of six 4-bit pixels) from the
// shared video RAM over a request/grant port. Words go into a 2-entry
// prefetch FIFO, and a word register feeds one nibble per pixel strobe.
//
// Ports:
//   clk, reset_n           system clock, async active-low reset
//   line_start, line_num   start scanout of a line (pulse + line index)
//   pix_en                 pixel strobe
//   mem_req/addr/gnt/data  RAM read port (data valid the cycle after grant)
//   pixel, pixel_valid     registered pixel output
//   line_done              pulse after the 384th pixel
//   underrun               sticky: a pixel was demanded with no data
//
// state  | meaning
// IDLE   | no line active, pixel strobes ignored
// FETCH  | issuing reads for the current line, pixels may be emitted
// DRAIN  | all 64 words granted, emitting the remaining pixels

module video_scanout_reader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic [7:0]  line_num,
    input  logic        pix_en,
    output logic        mem_req,
    output logic [13:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [23:0] mem_data,
    output logic [3:0]  pixel,
    output logic        pixel_valid,
    output logic        line_done,
    output logic        underrun
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    localparam logic [8:0] PIX_PER_LINE = 9'd384;

    state_t      state_q, state_d;
    logic [7:0]  line_q, line_d;
    logic [5:0]  word_cnt_q, word_cnt_d;
    logic        inflight_q, inflight_d;
    logic [23:0] fifo_mem_q [2];
    logic [23:0] fifo_mem_d [2];
    logic        fifo_wp_q, fifo_wp_d;
    logic        fifo_rp_q, fifo_rp_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [5:0]  pop_cnt_q, pop_cnt_d;     // line word index of the FIFO head
    logic        sh_vld_q, sh_vld_d;
    logic [5:0]  sh_word_q, sh_word_d;     // line word index held in the shifter
    logic [23:0] sh_data_q, sh_data_d;
    logic [8:0]  pix_cnt_q, pix_cnt_d;
    logic [5:0]  pix_word_q, pix_word_d;   // word/nibble of the next pixel due
    logic [2:0]  pix_nib_q, pix_nib_d;
    logic [3:0]  pixel_q, pixel_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        line_done_q, line_done_d;
    logic        underrun_q, underrun_d;

    logic [2:0]  occ;
    logic        gnt_ok, fifo_ne, sh_hit, sh_stale, head_hit;
    logic        emit, last_nib, avail, load;
    logic [23:0] fifo_head, cur_word;

    function automatic logic [3:0] nib_sel(input logic [23:0] w, input logic [2:0] i);
        case (i)
            3'd0:    nib_sel = w[23:20];
            3'd1:    nib_sel = w[19:16];
            3'd2:    nib_sel = w[15:12];
            3'd3:    nib_sel = w[11:8];
            3'd4:    nib_sel = w[7:4];
            3'd5:    nib_sel = w[3:0];
            default: nib_sel = 4'h0;
        endcase
    endfunction

    assign occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign mem_req   = (state_q == S_FETCH) && (occ < 3'd2);
    assign mem_addr  = {line_q, word_cnt_q};
    assign gnt_ok    = mem_req && mem_gnt;
    assign fifo_ne   = (fifo_cnt_q != 2'd0);
    assign fifo_head = fifo_mem_q[fifo_rp_q];

    // Alignment is kept by word index: words older than the pixel position
    // (left behind by underruns) are dropped instead of being displayed.
    assign sh_hit    = sh_vld_q && (sh_word_q == pix_word_q);
    assign sh_stale  = sh_vld_q && (sh_word_q < pix_word_q);
    assign head_hit  = fifo_ne && (pop_cnt_q == pix_word_q);
    assign emit      = pix_en && (state_q != S_IDLE) && (pix_cnt_q != PIX_PER_LINE) && !line_start;
    assign last_nib  = (pix_nib_q == 3'd5);
    assign avail     = sh_hit || head_hit;
    assign cur_word  = sh_hit ? sh_data_q : fifo_head;
    assign load      = fifo_ne && (!sh_vld_q || sh_stale || (emit && sh_hit && last_nib));

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        word_cnt_d    = word_cnt_q;
        inflight_d    = gnt_ok;
        fifo_mem_d    = fifo_mem_q;
        fifo_wp_d     = fifo_wp_q;
        fifo_rp_d     = fifo_rp_q;
        fifo_cnt_d    = fifo_cnt_q;
        pop_cnt_d     = pop_cnt_q;
        sh_vld_d      = sh_vld_q;
        sh_word_d     = sh_word_q;
        sh_data_d     = sh_data_q;
        pix_cnt_d     = pix_cnt_q;
        pix_word_d    = pix_word_q;
        pix_nib_d     = pix_nib_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        line_done_d   = 1'b0;
        underrun_d    = underrun_q;

        if (gnt_ok) begin
            word_cnt_d = word_cnt_q + 6'd1;
            if (word_cnt_q == 6'd63) begin
                state_d = S_DRAIN;
            end
        end

        if (state_q == S_DRAIN && pix_cnt_q == PIX_PER_LINE) begin
            state_d     = S_IDLE;
            line_done_d = 1'b1;
        end

        if (inflight_q) begin
            fifo_mem_d[fifo_wp_q] = mem_data;
            fifo_wp_d             = ~fifo_wp_q;
        end
        if (load) begin
            fifo_rp_d = ~fifo_rp_q;
            pop_cnt_d = pop_cnt_q + 6'd1;
        end
        case ({inflight_q, load})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (load) begin
            sh_vld_d  = 1'b1;
            sh_data_d = fifo_head;
            sh_word_d = pop_cnt_q;
        end else if (sh_stale || (emit && sh_hit && last_nib)) begin
            sh_vld_d  = 1'b0;
        end

        if (emit) begin
            pixel_valid_d = 1'b1;
            pixel_d       = avail ? nib_sel(cur_word, pix_nib_q) : 4'h0;
            if (!avail) begin
                underrun_d = 1'b1;
            end
            pix_cnt_d = pix_cnt_q + 9'd1;
            if (last_nib) begin
                pix_nib_d  = 3'd0;
                pix_word_d = pix_word_q + 6'd1;
            end else begin
                pix_nib_d  = pix_nib_q + 3'd1;
            end
        end

        // Restart wins over everything; a read granted now or last cycle
        // belongs to the old line and must not reach the new one.
        if (line_start) begin
            state_d    = S_FETCH;
            line_d     = line_num;
            word_cnt_d = 6'd0;
            inflight_d = 1'b0;
            fifo_wp_d  = 1'b0;
            fifo_rp_d  = 1'b0;
            fifo_cnt_d = 2'd0;
            pop_cnt_d  = 6'd0;
            sh_vld_d   = 1'b0;
            pix_cnt_d  = 9'd0;
            pix_word_d = 6'd0;
            pix_nib_d  = 3'd0;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            line_q        <= 8'd0;
            word_cnt_q    <= 6'd0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= 24'd0;
            fifo_mem_q[1] <= 24'd0;
            fifo_wp_q     <= 1'b0;
            fifo_rp_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            pop_cnt_q     <= 6'd0;
            sh_vld_q      <= 1'b0;
            sh_word_q     <= 6'd0;
            sh_data_q     <= 24'd0;
            pix_cnt_q     <= 9'd0;
            pix_word_q    <= 6'd0;
            pix_nib_q     <= 3'd0;
            pixel_q       <= 4'd0;
            pixel_valid_q <= 1'b0;
            line_done_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            word_cnt_q    <= word_cnt_d;
            inflight_q    <= inflight_d;
            fifo_mem_q    <= fifo_mem_d;
            fifo_wp_q     <= fifo_wp_d;
            fifo_rp_q     <= fifo_rp_d;
            fifo_cnt_q    <= fifo_cnt_d;
            pop_cnt_q     <= pop_cnt_d;
            sh_vld_q      <= sh_vld_d;
            sh_word_q     <= sh_word_d;
            sh_data_q     <= sh_data_d;
            pix_cnt_q     <= pix_cnt_d;
            pix_word_q    <= pix_word_d;
            pix_nib_q     <= pix_nib_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            line_done_q   <= line_done_d;
            underrun_q    <= underrun_d;
        end
    end

    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign line_done   = line_done_q;
    assign underrun    = underrun_q;

endmodule
